// File: rtl/sine_incr_decoder.sv
// sine_incr_decoder
// Receive end of the sine generator path. Watches an unsigned sample stream
// for rising midpoint crossings (with hysteresis) and measures the number of
// samples spanned by NPER = 2^LOG2_NPER periods. From that window total it
// recovers the phase increment that produced the stream:
//   incr_out = floor(2^(ADDRESS_WIDTH+LOG2_NPER) / total), saturated to WIDTH bits.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   en         in   sample valid; din is consumed only when en=1
//   din        in   DATA_WIDTH unsigned sample
//   incr_out   out  WIDTH recovered phase increment
//   period_out out  CNT_WIDTH average period in samples (total >> LOG2_NPER)
//   valid      out  one-cycle pulse when incr_out/period_out update
//   locked     out  high while measurements are being produced
module sine_incr_decoder #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int HYST          = 16,
    parameter int LOG2_NPER     = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [WIDTH-1:0]      incr_out,
    output logic [CNT_WIDTH-1:0]  period_out,
    output logic                  valid,
    output logic                  locked
);

    localparam int NPER   = 1 << LOG2_NPER;
    // Numerator 2^(ADDRESS_WIDTH+LOG2_NPER) needs one bit more than its exponent;
    // the quotient can be as wide as the numerator.
    localparam int NUM_W  = ADDRESS_WIDTH + LOG2_NPER + 1;
    localparam int DCNT_W = $clog2(NUM_W + 1);
    localparam int MID    = 1 << (DATA_WIDTH - 1);

    localparam logic [DATA_WIDTH:0]  LOW_TH  = (DATA_WIDTH+1)'(MID - HYST);
    localparam logic [DATA_WIDTH:0]  HIGH_TH = (DATA_WIDTH+1)'(MID + HYST);
    localparam logic [CNT_WIDTH-1:0] TOT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [LOG2_NPER:0]   PER_LAST = (LOG2_NPER+1)'(NPER - 1);

    typedef enum logic [1:0] {LVL_UNKNOWN, LVL_LOW, LVL_HIGH} level_t;
    typedef enum logic {SEEK, MEASURE} state_t;

    level_t                level_reg, level_next;
    state_t                state_reg, state_next;
    logic [CNT_WIDTH-1:0]  tot_reg, tot_next;
    logic [LOG2_NPER:0]    per_reg, per_next;
    logic                  start_div;
    logic                  timeout;

    logic                  div_busy_reg;
    logic [DCNT_W-1:0]     div_cnt_reg;
    logic [NUM_W-1:0]      num_reg;
    logic [NUM_W-1:0]      quo_reg;
    logic [CNT_WIDTH-1:0]  rem_reg;
    logic [CNT_WIDTH-1:0]  den_reg;

    logic [DATA_WIDTH:0]   din_ext;
    logic                  is_low, is_high, rising;
    logic                  div_free;
    logic [CNT_WIDTH:0]    rem_shift;
    logic                  div_ge;
    logic [CNT_WIDTH-1:0]  rem_sub;
    logic [WIDTH-1:0]      quo_sat;

    assign din_ext = {1'b0, din};
    assign is_low  = din_ext < LOW_TH;
    assign is_high = din_ext >= HIGH_TH;
    // Only a confirmed LOW -> HIGH move counts; UNKNOWN -> HIGH does not.
    assign rising  = en && (level_reg == LVL_LOW) && is_high;

    // The divider can accept a new window when idle, or on the very cycle it
    // publishes its result (that cycle no longer needs the operand registers).
    assign div_free = !div_busy_reg || (div_cnt_reg == '0);

    // ---------------- level tracker / measurement FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_reg <= LVL_UNKNOWN;
            state_reg <= SEEK;
            tot_reg   <= '0;
            per_reg   <= '0;
        end else begin
            level_reg <= level_next;
            state_reg <= state_next;
            tot_reg   <= tot_next;
            per_reg   <= per_next;
        end
    end

    always_comb begin
        level_next = level_reg;
        state_next = state_reg;
        tot_next   = tot_reg;
        per_next   = per_reg;
        start_div  = 1'b0;
        timeout    = 1'b0;
        if (en) begin
            if (is_low) begin
                level_next = LVL_LOW;
            end else if (is_high) begin
                level_next = LVL_HIGH;
            end
            case (state_reg)
                SEEK: begin
                    if (rising) begin
                        state_next = MEASURE;
                        tot_next   = CNT_WIDTH'(1);
                        per_next   = '0;
                    end
                end
                MEASURE: begin
                    if (tot_reg == TOT_MAX) begin
                        // No closing edge before the counter would overflow.
                        timeout    = 1'b1;
                        state_next = SEEK;
                        tot_next   = '0;
                        per_next   = '0;
                    end else if (rising && (per_reg == PER_LAST)) begin
                        // Closing edge: tot_reg counts opening edge through the
                        // sample before this one. This edge opens the next window.
                        // A window closing while the divider is busy is dropped.
                        start_div = div_free;
                        tot_next  = CNT_WIDTH'(1);
                        per_next  = '0;
                    end else begin
                        tot_next = tot_reg + CNT_WIDTH'(1);
                        if (rising) begin
                            per_next = per_reg + (LOG2_NPER+1)'(1);
                        end
                    end
                end
                default: state_next = SEEK;
            endcase
        end
    end

    // ---------------- restoring divider ----------------
    // Numerator bits are shifted in MSB first; one quotient bit per cycle.
    assign rem_shift = {rem_reg, num_reg[NUM_W-1]};
    assign div_ge    = rem_shift >= {1'b0, den_reg};
    // When div_ge holds the difference is below den_reg, so the low bits suffice.
    assign rem_sub   = rem_shift[CNT_WIDTH-1:0] - den_reg;

    generate
        if (NUM_W > WIDTH) begin : g_sat
            assign quo_sat = (|quo_reg[NUM_W-1:WIDTH]) ? {WIDTH{1'b1}} : quo_reg[WIDTH-1:0];
        end else begin : g_nosat
            assign quo_sat = WIDTH'(quo_reg);
        end
    endgenerate

    // Timing: load on the closing-edge cycle, NUM_W iterations, then publish,
    // giving NUM_W+1 = ADDRESS_WIDTH+LOG2_NPER+2 cycles from closing edge to valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_busy_reg <= 1'b0;
            div_cnt_reg  <= '0;
            num_reg      <= '0;
            quo_reg      <= '0;
            rem_reg      <= '0;
            den_reg      <= '0;
            incr_out     <= '0;
            period_out   <= '0;
            valid        <= 1'b0;
            locked       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (timeout) begin
                div_busy_reg <= 1'b0;
                div_cnt_reg  <= '0;
                locked       <= 1'b0;
            end else begin
                if (div_busy_reg) begin
                    if (div_cnt_reg != '0) begin
                        rem_reg     <= div_ge ? rem_sub : rem_shift[CNT_WIDTH-1:0];
                        quo_reg     <= {quo_reg[NUM_W-2:0], div_ge};
                        num_reg     <= num_reg << 1;
                        div_cnt_reg <= div_cnt_reg - DCNT_W'(1);
                    end else begin
                        incr_out     <= quo_sat;
                        period_out   <= den_reg >> LOG2_NPER;
                        valid        <= 1'b1;
                        locked       <= 1'b1;
                        div_busy_reg <= 1'b0;
                    end
                end
                if (start_div) begin
                    div_busy_reg <= 1'b1;
                    div_cnt_reg  <= DCNT_W'(NUM_W);
                    num_reg      <= {1'b1, {(NUM_W-1){1'b0}}};
                    quo_reg      <= '0;
                    rem_reg      <= '0;
                    den_reg      <= tot_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_sine_incr_decoder.sv
module tb_sine_incr_decoder;

    localparam int WIDTH     = 8;
    localparam int AW        = 8;
    localparam int DW        = 8;
    localparam int HYST      = 16;
    localparam int LOG2_NPER = 2;
    localparam int CNT_WIDTH = 16;
    localparam int NPER      = 1 << LOG2_NPER;
    localparam int MID       = 1 << (DW - 1);
    localparam int L         = AW + LOG2_NPER + 2;
    localparam longint NUMER   = 64'd1 << (AW + LOG2_NPER);
    localparam longint CNT_MAX = (64'd1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 en  = 1'b0;
    logic [DW-1:0]        din = '0;
    logic [WIDTH-1:0]     incr_out;
    logic [CNT_WIDTH-1:0] period_out;
    logic                 valid;
    logic                 locked;

    sine_incr_decoder #(
        .WIDTH(WIDTH), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .HYST(HYST), .LOG2_NPER(LOG2_NPER), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .din(din),
        .incr_out(incr_out), .period_out(period_out),
        .valid(valid), .locked(locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    longint cycle = 0;

    logic [7:0] rom [256];
    logic [7:0] phase;

    // ---------------- reference model ----------------
    // Works on global sample indices: a window total is simply the distance
    // between the opening and closing edge sample indices.
    typedef struct {
        longint cyc;
        int     incr;
        int     period;
    } event_t;

    event_t ev_q[$];
    int     m_level;          // 0 unknown, 1 low, 2 high
    bit     m_measuring;
    longint m_sample_idx;
    longint m_open_idx;
    int     m_edges;
    longint m_div_free;
    int     m_incr;
    int     m_period;
    bit     m_locked;
    longint m_last_total;

    task automatic model_reset();
        ev_q.delete();
        m_level = 0; m_measuring = 0; m_sample_idx = 0; m_open_idx = 0;
        m_edges = 0; m_div_free = 0; m_incr = 0; m_period = 0; m_locked = 0;
        m_last_total = 0;
    endtask

    task automatic model_edge(input bit e, input int d);
        bit     rising;
        longint total;
        longint q;
        event_t ev;
        if (!e) return;
        m_sample_idx++;
        rising = (m_level == 1) && (d >= MID + HYST);
        if (d < MID - HYST) m_level = 1;
        else if (d >= MID + HYST) m_level = 2;
        if (!m_measuring) begin
            if (rising) begin
                m_measuring = 1; m_open_idx = m_sample_idx; m_edges = 0;
            end
        end else if (m_sample_idx - m_open_idx == CNT_MAX) begin
            m_measuring = 0; m_locked = 0; ev_q.delete(); m_div_free = 0;
        end else if (rising) begin
            m_edges++;
            if (m_edges == NPER) begin
                total = m_sample_idx - m_open_idx;
                m_last_total = total;
                if (cycle >= m_div_free) begin
                    q = NUMER / total;
                    if (q > (1 << WIDTH) - 1) q = (1 << WIDTH) - 1;
                    ev.cyc = cycle + L; ev.incr = int'(q); ev.period = int'(total / NPER);
                    ev_q.push_back(ev);
                    m_div_free = cycle + L;
                end
                m_open_idx = m_sample_idx;
                m_edges = 0;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
            if (n_fail >= 50) begin
                $display("%0d/%0d checks passed", n_pass, n_checks);
                $finish;
            end
        end
    endtask

    task automatic step(input bit e, input logic [7:0] d);
        bit     exp_valid;
        event_t ev;
        en = e; din = d;
        @(posedge clk);
        cycle++;
        model_edge(e, int'(d));
        #1;
        exp_valid = 0;
        if (ev_q.size() > 0 && ev_q[0].cyc == cycle) begin
            ev = ev_q.pop_front();
            m_incr = ev.incr; m_period = ev.period; m_locked = 1; exp_valid = 1;
        end
        check("valid", valid, exp_valid);
        check("locked", locked, m_locked);
        check("incr_out", incr_out, m_incr);
        check("period_out", period_out, m_period);
        if (valid)
            $display("cycle %0d: update incr_out=%0d period_out=%0d locked=%0b",
                     cycle, incr_out, period_out, locked);
    endtask

    task automatic apply_reset();
        en = 0; din = '0; rst = 0;
        repeat (2) @(posedge clk);
        cycle += 2;
        #1;
        model_reset();
        check("rst_incr", incr_out, 0);
        check("rst_period", period_out, 0);
        check("rst_valid", valid, 0);
        check("rst_locked", locked, 0);
        rst = 1;
    endtask

    // Sine stream at a given phase step; waits for n_valid updates within budget.
    task automatic run_stream(input int stepv, input bit rand_en, input int n_valid, input int budget);
        int got;
        int k;
        bit e;
        got = 0; k = 0;
        while (got < n_valid && k < budget) begin
            e = rand_en ? bit'($urandom_range(0, 1)) : 1'b1;
            if (e) begin
                step(1'b1, rom[phase]);
                phase = 8'(int'(phase) + stepv);
            end else begin
                step(1'b0, 8'($urandom));
            end
            if (valid) got++;
            k++;
        end
        check($sformatf("stream_step%0d_updates", stepv), got, n_valid);
    endtask

    typedef struct {
        int stepv;
        bit rand_en;
        int exp_incr;
        int exp_period;
    } vec_t;

    vec_t vecs[6];
    int   nv;
    int   k;

    initial begin
        for (int i = 0; i < 256; i++)
            rom[i] = 8'(int'(128.0 + 127.0 * $sin(6.283185307179586 * i / 256.0)));

        vecs[0] = '{4,  1'b0, 4,  64};
        vecs[1] = '{1,  1'b0, 1,  256};
        vecs[2] = '{8,  1'b0, 8,  32};
        vecs[3] = '{4,  1'b1, 4,  64};
        vecs[4] = '{16, 1'b0, 16, 16};
        vecs[5] = '{2,  1'b1, 2,  128};

        model_reset();

        // Table-driven sine streams
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            phase = 8'($urandom);
            run_stream(vecs[i].stepv, vecs[i].rand_en, 2, 12000);
            check($sformatf("vec%0d_incr", i), incr_out, vecs[i].exp_incr);
            check($sformatf("vec%0d_period", i), period_out, vecs[i].exp_period);
            check($sformatf("vec%0d_locked", i), locked, 1);
        end

        // Non-dividing step: window total alternates between 341 and 342
        apply_reset();
        phase = 8'($urandom);
        run_stream(3, 1'b0, 2, 12000);
        check("step3_period", period_out, 85);
        check("step3_incr", incr_out, (m_last_total > 0) ? NUMER / m_last_total : 0);

        // Two-sample square wave: windows of 8 samples, shorter than the divider
        // latency, so every other window is dropped
        apply_reset();
        for (int j = 0; j < 200; j++) step(1'b1, (j % 2 == 1) ? 8'd255 : 8'd0);
        check("square_incr", incr_out, 128);
        check("square_period", period_out, 2);
        check("square_locked", locked, 1);

        // Constant midpoint: never leaves SEEK
        apply_reset();
        nv = 0;
        for (int j = 0; j < 1500; j++) begin
            step(1'b1, 8'd128);
            if (valid) nv++;
        end
        check("const_no_valid", nv, 0);
        check("const_locked", locked, 0);

        // Lock at step 8, then hold high until the window counter times out
        apply_reset();
        phase = 8'($urandom);
        run_stream(8, 1'b0, 1, 3000);
        check("pre_timeout_locked", locked, 1);
        nv = 0;
        k = 0;
        while (locked && k < 66000) begin
            step(1'b1, 8'd200);
            if (valid) nv++;
            k++;
        end
        check("timeout_locked", locked, 0);
        check("timeout_incr_hold", incr_out, 8);
        check("timeout_period_hold", period_out, 32);
        check("timeout_no_valid", nv, 0);

        // Asynchronous reset in the middle of a divide
        apply_reset();
        phase = 8'($urandom);
        run_stream(4, 1'b0, 1, 3000);
        k = 0;
        while (ev_q.size() == 0 && k < 2000) begin
            step(1'b1, rom[phase]);
            phase = 8'(int'(phase) + 4);
            k++;
        end
        check("mid_divide_reached", (k < 2000) ? 1 : 0, 1);
        repeat (3) begin
            step(1'b1, rom[phase]);
            phase = 8'(int'(phase) + 4);
        end
        check("pre_rst_incr", incr_out, 4);
        #2;
        rst = 0;
        #1;
        check("async_rst_incr", incr_out, 0);
        check("async_rst_period", period_out, 0);
        check("async_rst_valid", valid, 0);
        check("async_rst_locked", locked, 0);
        model_reset();
        @(posedge clk);
        cycle++;
        #1;
        rst = 1;
        phase = 8'($urandom);
        run_stream(4, 1'b0, 1, 3000);
        check("relock_incr", incr_out, 4);
        check("relock_period", period_out, 64);
        check("relock_locked", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
